// File: rtl/mem_stage_cached_if.sv
// Backing-memory port of the cached MEM stage: line refill reads and
// word write-through stores.
interface mem_stage_cached_if #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);
  // mem_req is held high, with mem_addr/mem_we/mem_wdata stable, until the
  // matching one-cycle completion pulse: mem_rvalid (with mem_rdata) ends a
  // line read, mem_wack ends a word write. Only one transfer is ever open.
  logic                         mem_req;
  logic                         mem_we;
  logic [DATA_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_rvalid;
  logic [LINE_WORDS*DATA_W-1:0] mem_rdata;
  logic                         mem_wack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata, mem_wack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata, mem_wack
  );
endinterface

// File: rtl/mem_stage_cached.sv
// MEM pipeline stage: E->M register plus a direct-mapped, write-through,
// no-write-allocate data cache that stalls the pipe on misses and stores.
module mem_stage_cached #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jumpE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemReadE,
  input  logic [3:0]        MemtoRegE,
  input  logic [4:0]        WriteRegE,
  input  logic [DATA_W-1:0] ALUMultOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [DATA_W-1:0] PCPlus4E,
  output logic              StallM,
  output logic              jumpM,
  output logic              RegWriteM,
  output logic              hitM,
  output logic [3:0]        MemtoRegM,
  output logic [4:0]        WriteRegM,
  output logic [DATA_W-1:0] ALUMultOutM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic [DATA_W-1:0] PCPlus8M,
  mem_stage_cached_if.master mem,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [1:0]        state_dbg
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              jump;
    logic              reg_write;
    logic              hit;
    logic [3:0]        memto_reg;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus8;
  } m_regs_t;

  state_t                                   state_q, state_d;
  m_regs_t                                  m_q, m_d;
  logic [SETS-1:0]                          valid_q, valid_d;
  logic [SETS-1:0][TAG_W-1:0]               tag_q, tag_d;
  logic [SETS-1:0][LINE_WORDS-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]                         hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]                         miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [DATA_W-1:0] line_addr;
  logic             hit;
  logic             load_hit;
  logic             stall;

  assign off       = ALUMultOutE[2 +: OFF_W];
  assign idx       = ALUMultOutE[2 + OFF_W +: IDX_W];
  assign tag       = ALUMultOutE[DATA_W-1 -: TAG_W];
  assign line_addr = {ALUMultOutE[DATA_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    load_hit     = 1'b0;
    stall        = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = '0;

    case (state_q)
      S_IDLE: begin
        // A store wins over a simultaneous load; it is written through
        // and only touches the cache if the line is already resident.
        if (MemWriteE) begin
          stall   = 1'b1;
          state_d = S_WRITE;
          if (hit) data_d[idx][off] = WriteDataE;
        end else if (MemReadE) begin
          if (hit) begin
            load_hit  = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            stall      = 1'b1;
            state_d    = S_REFILL;
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end
      end
      S_REFILL: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = line_addr;
        if (mem.mem_rvalid) begin
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          for (int w = 0; w < LINE_WORDS; w++)
            data_d[idx][w] = mem.mem_rdata[w*DATA_W +: DATA_W];
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        stall        = !mem.mem_wack;
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = ALUMultOutE;
        if (mem.mem_wack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // While stalled the E instruction is still waiting, so M gets a bubble.
    m_d = m_q;
    if (stall) begin
      m_d.jump      = 1'b0;
      m_d.reg_write = 1'b0;
      m_d.hit       = 1'b0;
    end else begin
      m_d.jump      = jumpE;
      m_d.reg_write = RegWriteE;
      m_d.hit       = load_hit;
      m_d.memto_reg = MemtoRegE;
      m_d.write_reg = WriteRegE;
      m_d.alu_out   = ALUMultOutE;
      m_d.pc_plus8  = PCPlus4E + DATA_W'(4);
      if (load_hit) m_d.read_data = data_q[idx][off];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data storage are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign StallM        = stall && rst;
  assign mem.mem_wdata = WriteDataE;
  assign jumpM         = m_q.jump;
  assign RegWriteM     = m_q.reg_write;
  assign hitM          = m_q.hit;
  assign MemtoRegM     = m_q.memto_reg;
  assign WriteRegM     = m_q.write_reg;
  assign ALUMultOutM   = m_q.alu_out;
  assign ReadDataM     = m_q.read_data;
  assign PCPlus8M      = m_q.pc_plus8;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_mem_stage_cached.sv
// Directed bench for mem_stage_cached: refill timing, hits, write-through
// stores, no-write-allocate, conflict misses, reset mid-refill, PC wrap.
module tb_mem_stage_cached;
  logic        clk = 1'b0;
  logic        rst;
  logic        jumpE, RegWriteE, MemWriteE, MemReadE;
  logic [3:0]  MemtoRegE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
  logic        StallM, jumpM, RegWriteM, hitM;
  logic [3:0]  MemtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUMultOutM, ReadDataM, PCPlus8M;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int stall_n;

  mem_stage_cached_if #(.DATA_W(32), .LINE_WORDS(4)) mem_bus ();

  mem_stage_cached #(.DATA_W(32), .LINE_WORDS(4), .SETS(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .jumpE(jumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
    .ALUMultOutE(ALUMultOutE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .StallM(StallM), .jumpM(jumpM), .RegWriteM(RegWriteM), .hitM(hitM),
    .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
    .ALUMultOutM(ALUMultOutM), .ReadDataM(ReadDataM), .PCPlus8M(PCPlus8M),
    .mem(mem_bus.master),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    jumpE = 0; RegWriteE = 0; MemWriteE = 0; MemReadE = 0;
    MemtoRegE = 4'h0; WriteRegE = 5'd0;
    ALUMultOutE = 32'h0; WriteDataE = 32'h0; PCPlus4E = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    drive_idle();
    MemReadE = 1; RegWriteE = 1; MemtoRegE = 4'h1; WriteRegE = rd;
    ALUMultOutE = addr; PCPlus4E = 32'h1000 + addr;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] d);
    drive_idle();
    MemWriteE = 1; ALUMultOutE = addr; WriteDataE = d; PCPlus4E = 32'h2000;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle refill latency: miss cycle, refill cycle with rvalid, retry hit.
  task automatic do_load_miss(input logic [31:0] addr, input logic [127:0] line,
                              input logic [31:0] word, input int exp_miss,
                              input int exp_hit, input string tag);
    drive_load(addr, 5'd3);
    #1;
    check({tag, "_stall_miss"}, StallM, 1);
    tick();
    check({tag, "_req"}, mem_bus.mem_req, 1);
    check({tag, "_we"}, mem_bus.mem_we, 0);
    check({tag, "_addr"}, mem_bus.mem_addr, addr & 32'hFFFF_FFF0);
    check({tag, "_miss_cnt"}, miss_cnt, 64'(exp_miss));
    mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = line;
    #1;
    check({tag, "_stall_refill"}, StallM, 1);
    tick();
    mem_bus.mem_rvalid = 0;
    #1;
    check({tag, "_stall_retry"}, StallM, 0);
    tick();
    check({tag, "_rdata"}, ReadDataM, word);
    check({tag, "_hitM"}, hitM, 1);
    check({tag, "_hit_cnt"}, hit_cnt, 64'(exp_hit));
    drive_idle();
  endtask

  initial begin
    drive_idle();
    mem_bus.mem_rvalid = 0; mem_bus.mem_wack = 0; mem_bus.mem_rdata = '0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_StallM", StallM, 0);
    check("rst_RegWriteM", RegWriteM, 0);
    check("rst_hitM", hitM, 0);
    check("rst_ReadDataM", ReadDataM, 0);
    check("rst_PCPlus8M", PCPlus8M, 0);
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_counters", {hit_cnt, miss_cnt}, 0);
    rst = 1;

    // Test 1: cold load 0x40, line arrives three cycles after the miss
    tick();
    drive_load(32'h40, 5'd5);
    #1;
    check("t1_stall_c0", StallM, 1);
    check("t1_req_c0", mem_bus.mem_req, 0);
    stall_n = int'(StallM);
    tick();
    #1;
    check("t1_req", mem_bus.mem_req, 1);
    check("t1_we", mem_bus.mem_we, 0);
    check("t1_addr", mem_bus.mem_addr, 32'h40);
    check("t1_bubble", RegWriteM, 0);
    stall_n += int'(StallM);
    tick();
    #1;
    stall_n += int'(StallM);
    tick();
    mem_bus.mem_rvalid = 1;
    mem_bus.mem_rdata  = {32'd4, 32'd3, 32'd2, 32'd1};
    #1;
    stall_n += int'(StallM);
    tick();
    mem_bus.mem_rvalid = 0;
    #1;
    stall_n += int'(StallM);
    check("t1_stall_cycles", 64'(stall_n), 4);
    tick();
    check("t1_rdata", ReadDataM, 1);
    check("t1_hitM", hitM, 1);
    check("t1_regwrite", RegWriteM, 1);
    check("t1_wreg", WriteRegM, 5);
    check("t1_pc8", PCPlus8M, 32'h1044);
    check("t1_miss_cnt", miss_cnt, 1);
    check("t1_hit_cnt", hit_cnt, 1);

    // Test 2: hit on the same line, no stall
    drive_load(32'h44, 5'd6);
    #1;
    check("t2_stall", StallM, 0);
    tick();
    check("t2_rdata", ReadDataM, 2);
    check("t2_hit_cnt", hit_cnt, 2);

    // Test 3: store hit 0x48 <- 0xDEAD, ack two cycles in
    drive_store(32'h48, 32'hDEAD);
    #1;
    stall_n = int'(StallM);
    tick();
    check("t3_bubble", RegWriteM, 0);
    check("t3_bubble_hit", hitM, 0);
    #1;
    check("t3_req", mem_bus.mem_req, 1);
    check("t3_we", mem_bus.mem_we, 1);
    check("t3_addr", mem_bus.mem_addr, 32'h48);
    check("t3_wdata", mem_bus.mem_wdata, 32'hDEAD);
    stall_n += int'(StallM);
    tick();
    mem_bus.mem_wack = 1;
    #1;
    stall_n += int'(StallM);
    check("t3_stall_cycles", 64'(stall_n), 2);
    tick();
    mem_bus.mem_wack = 0;
    check("t3_store_in_M", ALUMultOutM, 32'h48);
    check("t3_store_hitM", hitM, 0);
    drive_load(32'h48, 5'd7);
    #1;
    check("t3_load_nostall", StallM, 0);
    tick();
    check("t3_rdata", ReadDataM, 32'hDEAD);
    check("t3_hit_cnt", hit_cnt, 3);

    // Test 4: store miss does not allocate, so the following load misses
    drive_store(32'h400, 32'h1234);
    tick();
    mem_bus.mem_wack = 1;
    #1;
    check("t4_wack_stall", StallM, 0);
    tick();
    mem_bus.mem_wack = 0;
    do_load_miss(32'h400, {32'h0, 32'h0, 32'h0, 32'h1234}, 32'h1234, 2, 4, "t4");

    // Test 5: 0x40 and 0x440 share index 4 and evict each other
    do_load_miss(32'h440, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'hA0, 3, 5, "t5a");
    do_load_miss(32'h40,  {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 32'hB0, 4, 6, "t5b");
    do_load_miss(32'h444, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'hC1, 5, 7, "t5c");

    // Test 6: reset while refilling, then late rvalid
    drive_load(32'h80, 5'd2);
    tick();
    check("t6_req", mem_bus.mem_req, 1);
    rst = 0;
    #1;
    check("t6_rst_stall", StallM, 0);
    check("t6_rst_req", mem_bus.mem_req, 0);
    tick();
    mem_bus.mem_rvalid = 1;
    mem_bus.mem_rdata  = {32'h0, 32'h0, 32'h0, 32'hBAD};
    tick();
    mem_bus.mem_rvalid = 0;
    check("t6_rst_counters", {hit_cnt, miss_cnt}, 0);
    check("t6_rst_rdata", ReadDataM, 0);
    check("t6_rst_pc8", PCPlus8M, 0);
    rst = 1;
    drive_idle();
    tick();
    mem_bus.mem_rvalid = 1;
    tick();
    mem_bus.mem_rvalid = 0;
    check("t6_late_rvalid_state", state_dbg, 0);
    do_load_miss(32'h80, {32'h0, 32'h0, 32'h0, 32'h77}, 32'h77, 1, 1, "t6");

    // ALU op with PC+4 at the top of the address space
    jumpE = 1; RegWriteE = 1; WriteRegE = 5'd9; MemtoRegE = 4'h0;
    ALUMultOutE = 32'h123; PCPlus4E = 32'hFFFF_FFFC;
    #1;
    check("t6_alu_stall", StallM, 0);
    tick();
    check("t6_pc8_wrap", PCPlus8M, 32'h0);
    check("t6_alu_regwrite", RegWriteM, 1);
    check("t6_alu_jump", jumpM, 1);
    check("t6_alu_out", ALUMultOutM, 32'h123);
    check("t6_alu_wreg", WriteRegM, 9);
    check("t6_alu_hitM", hitM, 0);
    check("t6_rdata_hold", ReadDataM, 32'h77);
    drive_idle();
    tick();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
